// File: rtl/ofdm_pkg.sv
// Shared types and constants for the OFDM frame scheduler.
package ofdm_pkg;

    localparam int NFFT      = 64;
    localparam int PILOT_LEN = 127;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] i;
    } iq_t;

    // Payload carried through the output slot: sample plus its boundary flags.
    typedef struct packed {
        logic tuser;
        logic tlast;
        logic symb_tlast;
        iq_t  data;
    } beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-stream register slot; accepts a new beat whenever it is
// empty or its current beat is being taken downstream in the same cycle.
module axis_reg_slice #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    assign s_ready = ~m_valid | m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) m_data <= s_data;
        end
    end

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Frame sequencer: grants the output to the preamble source for PRE_SYMS
// symbols, then to the pilot-inserted data stream for cfg_nsym symbols.
//   state   | meaning
//   S_IDLE  | waiting for cfg_valid
//   S_PRE   | passing preamble samples, counting NFFT-sample symbols
//   S_DATA  | passing data samples, counting data symbols
//   S_DRAIN | frame too long on input: sinking data up to its tlast
module ofdm_symbol_scheduler #(
    parameter int NFFT      = ofdm_pkg::NFFT,
    parameter int PRE_SYMS  = 4,
    parameter int PILOT_LEN = ofdm_pkg::PILOT_LEN,
    parameter int NSYM_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [NSYM_W-1:0] cfg_nsym,
    input  logic              s_pre_tvalid,
    output logic              s_pre_tready,
    input  logic [31:0]       s_pre_tdata,
    input  logic              s_dat_tvalid,
    output logic              s_dat_tready,
    input  logic [31:0]       s_dat_tdata,
    input  logic              s_dat_symb_tlast,
    input  logic              s_dat_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_symb_tlast,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic [6:0]        pilot_idx,
    output logic              busy,
    output logic              err_len
);

    import ofdm_pkg::state_t;
    import ofdm_pkg::beat_t;
    import ofdm_pkg::S_IDLE;
    import ofdm_pkg::S_PRE;
    import ofdm_pkg::S_DATA;
    import ofdm_pkg::S_DRAIN;

    localparam int SAMP_W = $clog2(NFFT);

    state_t              state;
    state_t              state_nxt;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [NSYM_W-1:0]   sym_cnt;
    logic [NSYM_W-1:0]   nsym_q;
    logic [NSYM_W:0]     sym_inc;
    logic                slot_ready;
    logic                in_valid;
    logic                pre_acc;
    logic                dat_end;
    logic                drain_acc;
    logic                pre_sym_end;
    logic                pre_last;
    logic                dat_last_sym;
    logic                err_set;
    beat_t               beat_in;
    beat_t               beat_out;

    assign pre_sym_end  = samp_cnt == SAMP_W'(NFFT - 1);
    assign pre_last     = pre_sym_end && (sym_cnt == NSYM_W'(PRE_SYMS - 1));
    assign sym_inc      = {1'b0, sym_cnt} + 1'b1;
    assign dat_last_sym = sym_inc == {1'b0, nsym_q};

    // Acceptance terms use slot_ready directly so they do not loop through the tready outputs.
    assign pre_acc   = (state == S_PRE) && s_pre_tvalid && slot_ready;
    assign dat_end   = (state == S_DATA) && s_dat_tvalid && slot_ready && s_dat_symb_tlast;
    assign drain_acc = (state == S_DRAIN) && s_dat_tvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cfg_valid) state_nxt = S_PRE;
            S_PRE:   if (pre_acc && pre_last) state_nxt = (nsym_q == '0) ? S_IDLE : S_DATA;
            S_DATA: begin
                if (dat_end) begin
                    if (dat_last_sym)     state_nxt = s_dat_tlast ? S_IDLE : S_DRAIN;
                    else if (s_dat_tlast) state_nxt = S_IDLE;
                end
            end
            S_DRAIN: if (drain_acc && s_dat_tlast) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        s_pre_tready = 1'b0;
        s_dat_tready = 1'b0;
        in_valid     = 1'b0;
        beat_in      = '0;
        err_set      = 1'b0;
        case (state)
            S_PRE: begin
                s_pre_tready       = slot_ready;
                in_valid           = s_pre_tvalid;
                beat_in.data       = s_pre_tdata;
                beat_in.tuser      = 1'b1;
                beat_in.symb_tlast = pre_sym_end;
                beat_in.tlast      = pre_last && (nsym_q == '0);
            end
            S_DATA: begin
                s_dat_tready       = slot_ready;
                in_valid           = s_dat_tvalid;
                beat_in.data       = s_dat_tdata;
                beat_in.symb_tlast = s_dat_symb_tlast;
                beat_in.tlast      = s_dat_symb_tlast && (dat_last_sym || s_dat_tlast);
                // Input frame end and configured frame end must coincide.
                err_set            = dat_end && (dat_last_sym ^ s_dat_tlast);
            end
            S_DRAIN: s_dat_tready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt  <= '0;
            sym_cnt   <= '0;
            nsym_q    <= '0;
            pilot_idx <= '0;
            err_len   <= 1'b0;
        end else begin
            err_len <= err_set;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        nsym_q    <= cfg_nsym;
                        samp_cnt  <= '0;
                        sym_cnt   <= '0;
                        pilot_idx <= '0;
                    end
                end
                S_PRE: begin
                    if (pre_acc) begin
                        samp_cnt <= pre_sym_end ? '0 : samp_cnt + 1'b1;
                        if (pre_sym_end) sym_cnt <= pre_last ? '0 : sym_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (dat_end) begin
                        sym_cnt   <= sym_inc[NSYM_W-1:0];
                        pilot_idx <= (pilot_idx == 7'(PILOT_LEN - 1)) ? 7'd0 : pilot_idx + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    axis_reg_slice #(
        .W($bits(beat_t))
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .s_valid (in_valid),
        .s_ready (slot_ready),
        .s_data  (beat_in),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (beat_out)
    );

    assign m_axis_tdata      = beat_out.data;
    assign m_axis_tuser      = beat_out.tuser;
    assign m_axis_tlast      = beat_out.tlast;
    assign m_axis_symb_tlast = beat_out.symb_tlast;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Randomized bench for ofdm_symbol_scheduler: each frame's expected output
// beat list is computed from the frame rules and compared beat by beat.
module tb_ofdm_symbol_scheduler;

    localparam int NFFT      = 64;
    localparam int PRE_BEATS = 4 * NFFT;
    localparam int PILOT_LEN = 127;
    localparam int NSYM_W    = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [NSYM_W-1:0] cfg_nsym = '0;
    logic              s_pre_tvalid = 1'b0;
    logic              s_pre_tready;
    logic [31:0]       s_pre_tdata = '0;
    logic              s_dat_tvalid = 1'b0;
    logic              s_dat_tready;
    logic [31:0]       s_dat_tdata = '0;
    logic              s_dat_symb_tlast = 1'b0;
    logic              s_dat_tlast = 1'b0;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_symb_tlast;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic [6:0]        pilot_idx;
    logic              busy;
    logic              err_len;

    ofdm_symbol_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_nsym          (cfg_nsym),
        .s_pre_tvalid      (s_pre_tvalid),
        .s_pre_tready      (s_pre_tready),
        .s_pre_tdata       (s_pre_tdata),
        .s_dat_tvalid      (s_dat_tvalid),
        .s_dat_tready      (s_dat_tready),
        .s_dat_tdata       (s_dat_tdata),
        .s_dat_symb_tlast  (s_dat_symb_tlast),
        .s_dat_tlast       (s_dat_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_symb_tlast (m_axis_symb_tlast),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tuser      (m_axis_tuser),
        .pilot_idx         (pilot_idx),
        .busy              (busy),
        .err_len           (err_len)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pre_q[$];
    logic [31:0] dat_q[$];
    logic [41:0] exp_q[$];
    int          exp_total = 0;
    int          got_beats = 0;
    int          err_pulses = 0;
    bit          dat_ready_seen = 1'b0;
    bit          rnd_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [35:0] prev_out = '0;
    logic [35:0] cur_out;
    logic [41:0] exp_beat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected beats: {pilot_idx, tuser, tlast, symb_tlast, tdata}.
    // Output symbols = min(nsym, symbols offered); pilot advances as each
    // symbol's last beat is accepted, so it is already s+1 on that last beat.
    function automatic void build_exp(input int nsym, input int src);
        int out_syms;
        int pilot;
        exp_q.delete();
        out_syms = (src < nsym) ? src : nsym;
        for (int p = 0; p < PRE_BEATS; p++)
            exp_q.push_back({7'd0, 1'b1, 1'(nsym == 0 && p == PRE_BEATS - 1),
                             1'(p % NFFT == NFFT - 1), pre_q[p]});
        for (int s = 0; s < out_syms; s++) begin
            for (int j = 0; j < NFFT; j++) begin
                pilot = (s + ((j == NFFT - 1) ? 1 : 0)) % PILOT_LEN;
                exp_q.push_back({7'(pilot), 1'b0, 1'(j == NFFT - 1 && s == out_syms - 1),
                                 1'(j == NFFT - 1), dat_q[s * NFFT + j]});
            end
        end
        exp_total = exp_q.size();
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_out = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_symb_tlast, m_axis_tdata};
            if (prev_stall) check_eq("stall_hold", 64'(cur_out), 64'(prev_out));
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = cur_out;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_overrun", 64'(got_beats + 1), 64'(exp_total));
                end else begin
                    exp_beat = exp_q.pop_front();
                    check_eq("beat", 64'({pilot_idx, m_axis_tuser, m_axis_tlast,
                                          m_axis_symb_tlast, m_axis_tdata}), 64'(exp_beat));
                end
                got_beats++;
            end
            if (err_len) err_pulses++;
            if (s_dat_tready) dat_ready_seen = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // cfg_valid is held high with a junk count during the preamble: it must be ignored.
    task automatic send_pre(input int n, input bit final_src);
        int i = 0;
        int cyc = 0;
        cfg_valid = 1'b1;
        cfg_nsym  = NSYM_W'($urandom);
        while (i < n && cyc < 20000) begin
            s_pre_tvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            s_pre_tdata  = pre_q[i];
            @(negedge clk);
            if (s_pre_tvalid && s_pre_tready) i++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_pre_tvalid = 1'b0;
        cfg_valid    = 1'b0;
        check_eq("pre_beats_sent", 64'(i), 64'(n));
        if (final_src) check_eq("cfg_ready_after_last", 64'(cfg_ready), 64'd1);
    endtask

    task automatic send_dat(input int n, input int total, input bit final_src);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 20000) begin
            s_dat_tvalid     = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            s_dat_tdata      = dat_q[i];
            s_dat_symb_tlast = (i % NFFT == NFFT - 1);
            s_dat_tlast      = (i == total - 1);
            @(negedge clk);
            if (s_dat_tvalid && s_dat_tready) i++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_dat_tvalid     = 1'b0;
        s_dat_symb_tlast = 1'b0;
        s_dat_tlast      = 1'b0;
        check_eq("dat_beats_sent", 64'(i), 64'(n));
        if (final_src && n > 0) check_eq("cfg_ready_after_last", 64'(cfg_ready), 64'd1);
    endtask

    task automatic start_frame(input int nsym, input int src, input bit rnd);
        int w = 0;
        rnd_mode = rnd;
        pre_q.delete();
        dat_q.delete();
        for (int p = 0; p < PRE_BEATS; p++) pre_q.push_back($urandom);
        for (int k = 0; k < src * NFFT; k++) dat_q.push_back($urandom);
        build_exp(nsym, src);
        err_pulses     = 0;
        dat_ready_seen = 1'b0;
        got_beats      = 0;
        while (!cfg_ready && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("cfg_ready_wait", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_nsym  = NSYM_W'(nsym);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check_eq("busy_after_cfg", 64'(busy), 64'd1);
        if (!rnd) check_eq("pre_ready_after_cfg", 64'(s_pre_tready), 64'd1);
    endtask

    task automatic run_frame(input int nsym, input int src, input bit rnd);
        int w = 0;
        start_frame(nsym, src, rnd);
        fork
            send_pre(PRE_BEATS, nsym == 0);
            send_dat(src * NFFT, src * NFFT, nsym > 0);
        join
        while (exp_q.size() > 0 && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("beats_left", 64'(exp_q.size()), 64'd0);
        check_eq("beat_total", 64'(got_beats), 64'(exp_total));
        @(posedge clk);
        #1;
        check_eq("err_len_pulses", 64'(err_pulses), 64'((nsym > 0 && src != nsym) ? 1 : 0));
        if (nsym == 0) check_eq("dat_ready_never", 64'(dat_ready_seen), 64'd0);
        check_eq("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        int nsym;
        int src;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check_eq("rst_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                                     m_axis_symb_tlast, pilot_idx, busy, err_len}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(3, 3, 1'b0);
        run_frame(0, 0, 1'b0);
        run_frame(3, 3, 1'b1);
        run_frame(2, 1, 1'b0);
        run_frame(1, 3, 1'b0);
        for (int f = 0; f < 6; f++) begin
            nsym = $urandom_range(0, 4);
            src  = (nsym == 0) ? 0 : $urandom_range(1, 5);
            run_frame(nsym, src, 1'b1);
        end
        run_frame(130, 130, 1'b0);

        // Abandon a frame part-way through its second data symbol.
        start_frame(5, 5, 1'b0);
        fork
            send_pre(PRE_BEATS, 1'b0);
            send_dat(100, 5 * NFFT, 1'b0);
        join
        check_eq("pilot_before_rst", 64'(pilot_idx), 64'd1);
        check_eq("valid_before_rst", 64'(m_axis_tvalid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                                        m_axis_symb_tlast, pilot_idx, busy, err_len}), 64'd0);
        check_eq("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        check_eq("midrst_treadys", 64'({s_pre_tready, s_dat_tready}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_frame(1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
